// File: rtl/instr_seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants,
// state encoding and the opcode legality helper.
// Optional MDU wait state is compiled in when MDU_WAIT_EN is defined.
package instr_seq_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned STATE_W = 3;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
`ifdef MDU_WAIT_EN
        S_MDU    = 3'd4,
`endif
        S_WB     = 3'd5
    } seq_state_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op == OP_R)      || (op == OP_I)    || (op == OP_LOAD) ||
               (op == OP_STORE)  || (op == OP_BRANCH) ||
               (op == OP_JAL)    || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory access,
// optional multiply/divide wait and register write-back.
// Build option MDU_WAIT_EN adds the MDU state and the mdu_start/mdu_done
// handshake; without it M-type instructions go straight to write-back.
module instr_seq_ctrl
    import instr_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     instr,
    output logic [XLEN-1:0]     ir,
    input  logic [OP_W-1:0]     opcode,
    input  logic                fn7_1,
    input  logic [RD_W-1:0]     rd,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                mdu_start,
    input  logic                mdu_done,
    output logic                rf_we,
    output logic                pc_en,
    output logic                illegal,
    output logic [XLEN-1:0]     retire_cnt,
    output logic [STATE_W-1:0]  state
);

    seq_state_t cur_st;
    seq_state_t nxt_st;

    logic is_mem;
    logic is_store;

    assign is_store = (opcode == OP_STORE);
    assign is_mem   = (opcode == OP_LOAD) || is_store;
    assign state    = cur_st;

`ifndef MDU_WAIT_EN
    // The MDU handshake inputs have no effect in this build
    logic unused_mdu_inputs;
    assign unused_mdu_inputs = mdu_done ^ fn7_1;
`endif

    // Next-state routing and state-decoded control outputs; reset forces all low
    always_comb begin
        nxt_st    = cur_st;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mdu_start = 1'b0;
        rf_we     = 1'b0;
        pc_en     = 1'b0;
        illegal   = 1'b0;

        case (cur_st)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    nxt_st = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    nxt_st = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    pc_en   = 1'b1;
                    nxt_st  = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    nxt_st = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    pc_en  = 1'b1;
                    nxt_st = S_FETCH;
                end
`ifdef MDU_WAIT_EN
                else if ((opcode == OP_R) && fn7_1) begin
                    mdu_start = 1'b1;
                    nxt_st    = S_MDU;
                end
`endif
                else begin
                    nxt_st = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_en  = 1'b1;
                        nxt_st = S_FETCH;
                    end else begin
                        nxt_st = S_WB;
                    end
                end
            end
`ifdef MDU_WAIT_EN
            S_MDU: begin
                if (mdu_done) begin
                    nxt_st = S_WB;
                end
            end
`endif
            S_WB: begin
                rf_we  = (rd != '0);
                pc_en  = 1'b1;
                nxt_st = S_FETCH;
            end
            default: begin
                nxt_st = S_FETCH;
            end
        endcase

        if (rst) begin
            nxt_st    = S_FETCH;
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            mdu_start = 1'b0;
            rf_we     = 1'b0;
            pc_en     = 1'b0;
            illegal   = 1'b0;
        end
    end

    // State register, instruction register and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st     <= S_FETCH;
            ir         <= '0;
            retire_cnt <= '0;
        end else begin
            cur_st <= nxt_st;
            if ((cur_st == S_FETCH) && imem_ack) begin
                ir <= instr;
            end
            if (pc_en) begin
                retire_cnt <= retire_cnt + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed cases followed by random
// instruction streams against a per-instruction phase model.
module tb_instr_seq_ctrl;
    import instr_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] instr, ir;
    logic [6:0]  opcode;
    logic        fn7_1;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        mdu_start, mdu_done;
    logic        rf_we, pc_en, illegal;
    logic [31:0] retire_cnt;
    logic [2:0]  state;

    // External field decoder driven from the instruction register
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign fn7_1  = ir[25];

    instr_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr), .ir(ir),
        .opcode(opcode), .fn7_1(fn7_1), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .rf_we(rf_we), .pc_en(pc_en), .illegal(illegal),
        .retire_cnt(retire_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       mdu_start;
        logic       rf_we;
        logic       pc_en;
        logic       illegal;
    } obs_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_ir   = '0;
    logic [31:0] exp_cnt  = '0;
    bit          do_force = 1'b0;

    logic [6:0] legal_ops [7];

    function automatic obs_t mk(input seq_state_t s, input logic ireq, input logic dreq,
                                input logic dwe, input logic ms, input logic rfwe,
                                input logic pce, input logic ill);
        obs_t o;
        o.st = s; o.imem_req = ireq; o.dmem_req = dreq; o.dmem_we = dwe;
        o.mdu_start = ms; o.rf_we = rfwe; o.pc_en = pce; o.illegal = ill;
        return o;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o = {state, imem_req, dmem_req, dmem_we, mdu_start, rf_we, pc_en, illegal};
        return o;
    endfunction

    function automatic logic model_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk_obs(input string tag, input obs_t e);
        obs_t o;
        o = observed();
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s ctrl: got %h expected %h", tag, o, e);
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // One clock cycle: drive inputs at the falling edge, then check outputs
    task automatic step(input obs_t e, input logic ai, input logic ad, input logic md,
                        input logic [31:0] w, input string tag);
        @(negedge clk);
        imem_ack = ai;
        dmem_ack = ad;
        mdu_done = md;
        instr    = ai ? w : $urandom;
        #1;
        chk_obs(tag, e);
        chk32({tag, "_ir"}, ir, exp_ir);
        chk32({tag, "_retire"}, retire_cnt, exp_cnt);
        if (e.pc_en) exp_cnt = exp_cnt + 32'd1;
        if ((e.st == 3'(S_FETCH)) && ai) exp_ir = w;
        if (do_force) begin
            force dut.retire_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.retire_cnt;
            exp_cnt  = 32'hFFFF_FFFF;
            do_force = 1'b0;
        end
    endtask

    // Walk one instruction through its expected phases
    task automatic run_instr(input logic [31:0] w, input int di, input int dd, input int dm);
        logic [6:0] op;
        logic       st_op;
        logic       m_type;
        obs_t       f;
        op     = w[6:0];
        st_op  = (op == OP_STORE);
        m_type = (op == OP_R) && w[25];
        f      = mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < di; i++) step(f, 1'b0, rb(), rb(), w, "fetch_wait");
        step(f, 1'b1, rb(), rb(), w, "fetch_ack");
        if (!model_legal(op)) begin
            step(mk(S_DECODE, 0, 0, 0, 0, 0, 1, 1), rb(), rb(), rb(), w, "decode_illegal");
            return;
        end
        step(mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb(), w, "decode");
        if ((op == OP_LOAD) || st_op) begin
            step(mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb(), w, "exec_mem");
            for (int i = 0; i < dd; i++)
                step(mk(S_MEM, 0, 1, st_op, 0, 0, 0, 0), rb(), 1'b0, rb(), w, "mem_wait");
            step(mk(S_MEM, 0, 1, st_op, 0, 0, st_op, 0), rb(), 1'b1, rb(), w, "mem_ack");
            if (st_op) return;
        end else if (op == OP_BRANCH) begin
            step(mk(S_EXEC, 0, 0, 0, 0, 0, 1, 0), rb(), rb(), rb(), w, "exec_branch");
            return;
        end
`ifdef MDU_WAIT_EN
        else if (m_type) begin
            step(mk(S_EXEC, 0, 0, 0, 1, 0, 0, 0), rb(), rb(), rb(), w, "exec_mdu");
            for (int i = 0; i < dm - 1; i++)
                step(mk(S_MDU, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), 1'b0, w, "mdu_wait");
            step(mk(S_MDU, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), 1'b1, w, "mdu_done");
        end
`endif
        else begin
            if (m_type && (dm < 0)) $display("unexpected delay");
            step(mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb(), w, "exec");
        end
        step(mk(S_WB, 0, 0, 0, 0, (w[11:7] != 5'd0), 1, 0), rb(), rb(), rb(), w, "wb");
    endtask

    localparam logic [31:0] W_ADDI = 32'h0010_0093;
    localparam logic [31:0] W_LW   = 32'h0000_2103;
    localparam logic [31:0] W_SW   = 32'h0020_2023;
    localparam logic [31:0] W_ILL  = 32'h0000_007F;
    localparam logic [31:0] W_MUL  = 32'h0200_01B3;
    localparam logic [31:0] W_BEQ  = 32'h0000_0063;
    localparam logic [31:0] W_JAL  = 32'h0000_00EF;
    localparam logic [31:0] W_LUI  = 32'h0000_52B7;
    localparam logic [31:0] W_NOP  = 32'h0000_0013;

    initial begin
        logic [31:0] w;
        logic [6:0]  op;
        legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};

        // Reset with acknowledges asserted: everything must stay quiet
        rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; mdu_done = 1'b1; instr = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        chk_obs("reset", mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0));
        chk32("reset_ir", ir, 32'h0);
        chk32("reset_retire", retire_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
        #1;
        chk_obs("post_reset_fetch", mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0));

        // Directed instructions
        run_instr(W_ADDI, 0, 0, 1);
        run_instr(W_LW,   0, 3, 1);
        run_instr(W_SW,   1, 2, 1);
        run_instr(W_ILL,  0, 0, 1);
        run_instr(W_MUL,  0, 0, 5);
        run_instr(W_BEQ,  2, 0, 1);
        run_instr(W_JAL,  0, 0, 1);
        run_instr(W_LUI,  0, 0, 1);
        run_instr(W_NOP,  0, 0, 1);
        run_instr(W_LW,   0, 0, 1);

        // Reset while a load is waiting in MEM
        step(mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, W_LW, "rm_fetch");
        step(mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, W_LW, "rm_decode");
        step(mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, W_LW, "rm_exec");
        step(mk(S_MEM, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, W_LW, "rm_mem");
        @(negedge clk);
        rst = 1'b1; dmem_ack = 1'b1;
        #1;
        exp_ir = '0; exp_cnt = '0;
        chk_obs("rst_in_mem", mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0));
        chk32("rst_in_mem_ir", ir, exp_ir);
        chk32("rst_in_mem_retire", retire_cnt, exp_cnt);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk_obs("rst_release_fetch", mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0));

        // Counter wrap from all ones
        do_force = 1'b1;
        run_instr(W_ADDI, 0, 0, 1);
        run_instr(W_NOP, 0, 0, 1);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            if ($urandom_range(0, 8) < 7) begin
                op = legal_ops[$urandom_range(0, 6)];
            end else begin
                op = 7'($urandom);
                while (model_legal(op)) op = 7'($urandom);
            end
            w[6:0] = op;
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-high reset
 imem_req  out  1  instruction fetch request
 imem_ack  in  1  fetch complete; instr valid this cycle
 instr  in  32  fetched instruction word
 ir  out  32  instruction register, feeds the field decoder
 opcode  in  7  decoded opcode of ir
 fn7_1  in  1  decoded M-extension flag of ir
 rd  in  5  decoded destination register of ir
 dmem_req  out  1  data memory request
 dmem_we  out  1  data memory write, valid with dmem_req
 dmem_ack  in  1  data access complete
 mdu_start  out  1  one-cycle multiply/divide start pulse
 mdu_done  in  1  multiply/divide result ready
 rf_we  out  1  register-file write enable
 pc_en  out  1  one-cycle PC advance/commit pulse
 illegal  out  1  one-cycle unsupported-opcode pulse
 retire_cnt  out  32  retired-instruction count
 state  out  3  current FSM state encoding

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, MDU and WB.
REQ-004 FETCH: imem_req=1, held stable until imem_ack; on imem_ack, ir<=instr and go to DECODE. No timeout.
REQ-005 DECODE: one cycle. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 0110111. Legal opcode -> EXEC. Other opcodes: illegal=1 and pc_en=1 for this cycle, then FETCH.
REQ-006 EXEC: one cycle, routed by opcode:
 - load/store -> MEM
 - 0110011 with fn7_1=1 -> MDU with mdu_start=1 (see REQ-014)
 - branch 1100011 -> FETCH with pc_en=1
 - all others -> WB
REQ-007 MEM: dmem_req=1 and dmem_we=(opcode==0100011), both held until dmem_ack. On ack, a load goes to WB; a store goes to FETCH with pc_en=1.
REQ-008 MDU: wait for mdu_done, then go to WB. mdu_start SHALL NOT re-pulse while waiting.
REQ-009 WB: rf_we=(rd!=0) and pc_en=1 for exactly one cycle, then FETCH.
REQ-010 Every cycle with pc_en=1 SHALL increment retire_cnt by 1. The count wraps from FFFFFFFF to 0. Illegal instructions count as retired.
REQ-011 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored. ir changes only on a FETCH acknowledgment.
REQ-012 Latency for an ALU instruction with an immediate imem_ack is 4 cycles, FETCH through WB. A load with immediate acks takes 5 cycles.

Reset
REQ-013 While rst=1:
 - state=FETCH, ir=0, retire_cnt=0
 - every other output forced to 0, including imem_req
 Asserting rst mid-operation SHALL abandon any outstanding request without asserting rf_we or pc_en. The first cycle after deassertion SHALL be FETCH with imem_req=1.

Configuration
REQ-014 Macro MDU_WAIT_EN:
 - Defined: the MDU state, mdu_start and mdu_done exist, and M-type instructions follow REQ-006/REQ-008.
 - Undefined: the MDU state is absent, M-type instructions go EXEC -> WB, mdu_start is tied to 0, and mdu_done is ignored.

Structure
REQ-015 A shared package SHALL hold the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI) and the state enum type seq_state_t.
REQ-016 The block SHALL be a single module with no sub-module. The state register, ir and retire_cnt are flops; the outputs are decoded from state.

Verification
REQ-017 ADDI x1 instruction (00100093) with imem_ack in the first FETCH cycle -> rf_we=1 in cycle 4, pc_en=1 in cycle 4, retire_cnt=1.
REQ-018 LW x2 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we in the following cycle. SW -> dmem_we=1, no rf_we, pc_en on the ack cycle.
REQ-019 Opcode 1111111 -> illegal=1 and pc_en=1 in the DECODE cycle, no rf_we, next state FETCH.
REQ-020 MUL (fn7_1=1) with MDU_WAIT_EN and mdu_done 5 cycles after start -> one mdu_start pulse, rf_we after done. Without the macro -> WB directly after EXEC.
REQ-021 rst pulsed during MEM with dmem_req high -> dmem_req=0 immediately, no pc_en or rf_we, retire_cnt=0, FETCH after release.
REQ-022 retire_cnt preset via force to FFFFFFFF, then one retire -> 00000000.
